lisp_mem_responder: RTL and testbench



---
 rtl/lisp_mem_responder.sv | 115 +++++++++++
 tb/tb_lisp_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lisp_mem_responder.sv
// Cell-memory responder for the Lisp core: boot-fills a synchronous RAM after reset,
// then serves one read/write request per two cycles with a single-cycle response pulse.
module lisp_mem_responder #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DEPTH      = 4096,
   parameter logic [DATA_WIDTH-1:0] BOOT_FILL  = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  boot_done,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int                IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0]     LAST_CELL = IW'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {
      BOOT,
      IDLE,
      RESP
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [IW-1:0]         r_bootCnt;
   logic                  r_bootDone;
   logic                  r_respErr;
   logic                  r_respWrite;
   logic [DATA_WIDTH-1:0] r_wdataHold;
   logic [DATA_WIDTH-1:0] r_ramQ;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_inRange;
   logic                  w_bootLast;
   logic                  w_memWe;
   logic [IW-1:0]         w_memAddr;
   logic [DATA_WIDTH-1:0] w_memWdata;

   // Extra top bit keeps the compare correct when DEPTH equals 2**ADDR_WIDTH.
   assign w_inRange  = {1'b0, req_addr} < DEPTH_EXT;
   assign w_accept   = req_valid && (r_state == IDLE);
   assign w_bootLast = (r_bootCnt == LAST_CELL);

   always_comb begin
      w_nextState = r_state;
      w_memWe     = 1'b0;
      w_memAddr   = req_addr[IW-1:0];
      w_memWdata  = req_wdata;
      case (r_state)
         BOOT: begin
            w_memWe    = 1'b1;
            w_memAddr  = r_bootCnt;
            w_memWdata = BOOT_FILL;
            if (w_bootLast) w_nextState = IDLE;
         end
         IDLE: begin
            if (req_valid) begin
               w_nextState = RESP;
               w_memWe     = req_write && w_inRange;
            end
         end
         RESP:    w_nextState = IDLE;
         default: w_nextState = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_nextState;
   end

   // RAM has no reset so it stays a plain inferred block; boot overwrites it.
   always_ff @(posedge clk) begin
      if (w_memWe) r_mem[w_memAddr] <= w_memWdata;
      if (w_accept && !req_write && w_inRange) r_ramQ <= r_mem[w_memAddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bootCnt   <= '0;
         r_bootDone  <= 1'b0;
         r_respErr   <= 1'b0;
         r_respWrite <= 1'b0;
         r_wdataHold <= '0;
      end else begin
         if (r_state == BOOT) begin
            r_bootCnt <= w_bootLast ? '0 : r_bootCnt + 1'b1;
            if (w_bootLast) r_bootDone <= 1'b1;
         end
         if (w_accept) begin
            r_respErr   <= !w_inRange;
            r_respWrite <= req_write;
            r_wdataHold <= req_wdata;
         end
      end
   end

   assign boot_done  = r_bootDone;
   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_err   = resp_valid && r_respErr;
   assign resp_rdata = (!resp_valid || r_respErr) ? '0 :
                       (r_respWrite ? r_wdataHold : r_ramQ);

endmodule

// File: tb/tb_lisp_mem_responder.sv
// Self-checking bench for lisp_mem_responder: transaction-level model of boot,
// request acceptance and response contents, driven by directed and random requests.
module tb_lisp_mem_responder;

   localparam int          AW    = 12;
   localparam int          DW    = 8;
   localparam int          DEPTH = 16;
   localparam logic [7:0]  FILL  = 8'h00;

   logic          clk;
   logic          rst_n;
   logic          boot_done;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_err;

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] modelMem [DEPTH];
   bit         booted;
   int         bootEdges;
   bit         respNow;
   logic [7:0] respData;
   bit         respErr;

   lisp_mem_responder #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .BOOT_FILL(FILL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .boot_done(boot_done),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Holds reset for two edges, checks reset values, resets the model, releases
   // reset just after a posedge so the next posedge is the first boot write.
   task automatic doReset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_boot_done", 32'(boot_done), 32'(0));
      checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'(0));
      checkOutput("rst_resp_err", 32'(resp_err), 32'(0));
      checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'(0));
      booted    = 1'b0;
      bootEdges = 0;
      respNow   = 1'b0;
      respData  = '0;
      respErr   = 1'b0;
      for (int i = 0; i < DEPTH; i++) modelMem[i] = FILL;
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive a request, check this cycle's outputs against the
   // model, then advance the model across the edge.
   task automatic applyStimulus(input bit v, input bit w, input logic [AW-1:0] a, input logic [7:0] d);
      bit         expReady;
      bit         acc;
      bit         nextResp;
      bit         nextErr;
      bit         nextBooted;
      logic [7:0] nextData;
      int         idx;
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      expReady  = booted && !respNow;
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("boot_done", 32'(boot_done), 32'(booted));
      checkOutput("resp_valid", 32'(resp_valid), 32'(respNow));
      if (respNow) begin
         checkOutput("resp_err", 32'(resp_err), 32'(respErr));
         checkOutput("resp_rdata", 32'(resp_rdata), 32'(respData));
      end
      acc      = v && expReady;
      nextResp = acc;
      nextErr  = 1'b0;
      nextData = '0;
      if (acc) begin
         idx     = int'(a);
         nextErr = (idx >= DEPTH);
         if (!nextErr) begin
            if (w) begin
               modelMem[idx] = d;
               nextData      = d;
            end else begin
               nextData = modelMem[idx];
            end
         end
      end
      nextBooted = booted;
      if (!booted) begin
         bootEdges++;
         if (bootEdges == DEPTH) nextBooted = 1'b1;
      end
      @(posedge clk);
      #1;
      respNow  = nextResp;
      respData = nextData;
      respErr  = nextErr;
      booted   = nextBooted;
   endtask

   initial begin
      logic [AW-1:0] ra;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      doReset();

      // Quiet boot, then read a filled cell.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 12'h005, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);

      // Write then read-after-write two cycles later, plus out-of-range probes.
      applyStimulus(1'b1, 1'b1, 12'h00A, 8'hC3);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 12'h00A, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 12'h000, 8'h77);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 12'h010, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 12'h010, 8'hEE);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b1, 12'h02A, 8'hC3);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 12'h000, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 12'hFFF, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);

      // req_valid held high with alternating addresses.
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 12'h00A : 12'h000, 8'h00);
      applyStimulus(1'b0, 1'b0, '0, '0);

      // Random traffic, mostly in range with occasional out-of-range addresses.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) ra = 12'($urandom_range(16, 4095));
         else                           ra = 12'($urandom_range(0, DEPTH - 1));
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra, 8'($urandom));
      end
      applyStimulus(1'b0, 1'b0, '0, '0);

      // Reset asserted during the response cycle of a write.
      applyStimulus(1'b1, 1'b1, 12'h003, 8'h5A);
      checkOutput("pre_reset_resp_valid", 32'(resp_valid), 32'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("async_resp_valid", 32'(resp_valid), 32'(0));
      checkOutput("async_boot_done", 32'(boot_done), 32'(0));
      checkOutput("async_req_ready", 32'(req_ready), 32'(0));
      doReset();

      // Requests held during boot; first acceptance lands on the first IDLE cycle.
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 12'h003, 8'h00);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 1'b0, 12'(i), 8'h00);
         applyStimulus(1'b1, 1'b0, 12'(i), 8'h00);
      end
      applyStimulus(1'b0, 1'b0, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
